// File: rtl/lmmi_cfg_bridge_if.sv
// Host command/response and LMMI channel bundle for lmmi_cfg_bridge.
// The bridge uses the slave view; a host/target model uses the master view.
interface lmmi_cfg_bridge_if #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 5,
  parameter int CH_W     = 4
) ();
  logic                         cmd_valid_i;
  logic                         cmd_ready_o;
  logic [CH_W-1:0]              cmd_ch_i;
  logic                         cmd_wr_i;
  logic [OFFSET_W-1:0]          cmd_offset_i;
  logic [DATA_W-1:0]            cmd_wdata_i;
  logic                         rsp_valid_o;
  logic                         rsp_ready_i;
  logic [DATA_W-1:0]            rsp_rdata_o;
  logic [1:0]                   rsp_err_o;
  logic                         busy_o;
  logic [NUM_CH-1:0]            lmmi_request_o;
  logic [NUM_CH-1:0]            lmmi_wr_rdn_o;
  logic [NUM_CH*OFFSET_W-1:0]   lmmi_offset_o;
  logic [NUM_CH*DATA_W-1:0]     lmmi_wdata_o;
  logic [NUM_CH-1:0]            lmmi_ready_i;
  logic [NUM_CH*DATA_W-1:0]     lmmi_rdata_i;
  logic [NUM_CH-1:0]            lmmi_rdata_valid_i;

  modport slave (
    input  cmd_valid_i, cmd_ch_i, cmd_wr_i, cmd_offset_i, cmd_wdata_i, rsp_ready_i,
           lmmi_ready_i, lmmi_rdata_i, lmmi_rdata_valid_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
           lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o
  );

  modport master (
    output cmd_valid_i, cmd_ch_i, cmd_wr_i, cmd_offset_i, cmd_wdata_i, rsp_ready_i,
           lmmi_ready_i, lmmi_rdata_i, lmmi_rdata_valid_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
           lmmi_request_o, lmmi_wr_rdn_o, lmmi_offset_o, lmmi_wdata_o
  );
endinterface

// File: rtl/lmmi_cfg_bridge.sv
// Multi-channel LMMI configuration master: one host command at a time is routed
// to a selected LMMI target, with per-phase timeout and a single response.
module lmmi_cfg_bridge #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 5,
  parameter int CH_W     = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lmmi_cfg_bridge_if.slave   bus
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);
  localparam logic [CH_W:0]   NCH  = (CH_W + 1)'(NUM_CH);
  localparam logic [1:0] ERR_OK = 2'd0, ERR_TO = 2'd1, ERR_CH = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                wr_q, wr_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic                rdy_sel, vld_sel, tmo_hit;
  logic [DATA_W-1:0]   rdata_sel;

  // Only the latched channel's handshake inputs are ever looked at.
  always_comb begin
    rdy_sel   = 1'b0;
    vld_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        rdy_sel   = bus.lmmi_ready_i[k];
        vld_sel   = bus.lmmi_rdata_valid_i[k];
        rdata_sel = bus.lmmi_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign tmo_hit = (TIMEOUT != 0) && (timer_q == TMAX);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr_d    = wr_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          ch_d    = bus.cmd_ch_i;
          wr_d    = bus.cmd_wr_i;
          off_d   = bus.cmd_offset_i;
          wdata_d = bus.cmd_wdata_i;
          rdata_d = '0;
          timer_d = '0;
          if ({1'b0, bus.cmd_ch_i} >= NCH) begin
            err_d   = ERR_CH;
            state_d = RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A handshake event in the same cycle as expiry takes priority.
        if (rdy_sel) begin
          if (wr_q) begin
            state_d = RESP;
          end else if (vld_sel) begin
            rdata_d = rdata_sel;
            state_d = RESP;
          end else begin
            timer_d = '0;
            state_d = RDWAIT;
          end
        end else if (tmo_hit) begin
          err_d   = ERR_TO;
          state_d = RESP;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      RDWAIT: begin
        if (vld_sel) begin
          rdata_d = rdata_sel;
          state_d = RESP;
        end else if (tmo_hit) begin
          err_d   = ERR_TO;
          state_d = RESP;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      wr_q    <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wr_q    <= wr_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  logic [NUM_CH-1:0]          req_o, wrn_o;
  logic [NUM_CH*OFFSET_W-1:0] off_o;
  logic [NUM_CH*DATA_W-1:0]   wd_o;

  always_comb begin
    req_o = '0;
    wrn_o = '0;
    off_o = '0;
    wd_o  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_q == REQ && ch_q == CH_W'(k)) begin
        req_o[k]                        = 1'b1;
        wrn_o[k]                        = wr_q;
        off_o[k*OFFSET_W +: OFFSET_W]   = off_q;
        wd_o[k*DATA_W +: DATA_W]        = wdata_q;
      end
    end
  end

  assign bus.lmmi_request_o = req_o;
  assign bus.lmmi_wr_rdn_o  = wrn_o;
  assign bus.lmmi_offset_o  = off_o;
  assign bus.lmmi_wdata_o   = wd_o;
  // Held low while reset is asserted so the host never sees ready mid-reset.
  assign bus.cmd_ready_o    = (state_q == IDLE) && !rst_i;
  assign bus.rsp_valid_o    = (state_q == RESP);
  assign bus.rsp_rdata_o    = rdata_q;
  assign bus.rsp_err_o      = err_q;
  assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_lmmi_cfg_bridge.sv
// Self-checking bench for lmmi_cfg_bridge: directed table, random commands
// against a latency/status model, backpressure and reset-abort sequences.
module tb_lmmi_cfg_bridge;
  localparam int NUM_CH = 4, DATA_W = 8, OFFSET_W = 5, CH_W = 4, TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lmmi_cfg_bridge_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .CH_W(CH_W)) bus ();

  lmmi_cfg_bridge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .CH_W(CH_W),
                    .TIMEOUT(TIMEOUT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int ch; int wr; int off; int wdata; int rdy_dly; int vld_dly; int rdata; int bp;
    int exp_err; int exp_rdata; int exp_req; int exp_lat;
  } vec_t;

  typedef struct { int err; int rdata; int req; int lat; } exp_t;

  // Expected outcome straight from the handshake/timeout rules.
  function automatic exp_t model(input int ch, input int wr, input int rdy, input int vld, input int data);
    exp_t e;
    if (ch >= NUM_CH) begin
      e.err = 2; e.rdata = 0; e.req = 0; e.lat = 1;
    end else if (rdy > TIMEOUT) begin
      e.err = 1; e.rdata = 0; e.req = TIMEOUT + 1; e.lat = TIMEOUT + 2;
    end else if (wr != 0 || vld == 0) begin
      e.err = 0; e.rdata = (wr != 0) ? 0 : data; e.req = rdy + 1; e.lat = rdy + 2;
    end else if (vld - 1 <= TIMEOUT) begin
      e.err = 0; e.rdata = data; e.req = rdy + 1; e.lat = rdy + 1 + vld + 1;
    end else begin
      e.err = 1; e.rdata = 0; e.req = rdy + 1; e.lat = rdy + 1 + TIMEOUT + 1 + 1;
    end
    return e;
  endfunction

  // Entered and left at posedge+1 with the bridge idle.
  task automatic run_txn(input vec_t v, input string tag);
    int reqcnt;
    int lat;
    logic [31:0] exp_v;
    logic [DATA_W-1:0] hold_rd;
    logic [1:0] hold_err;
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_ch_i     = CH_W'(v.ch);
    bus.cmd_wr_i     = (v.wr != 0);
    bus.cmd_offset_i = OFFSET_W'(v.off);
    bus.cmd_wdata_i  = DATA_W'(v.wdata);
    @(posedge clk); #1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_ch_i     = CH_W'($urandom);
    bus.cmd_wdata_i  = DATA_W'($urandom);
    reqcnt = 0;
    lat    = 0;
    for (int c = 1; c < 1000; c++) begin
      bus.lmmi_ready_i       = NUM_CH'($urandom);
      bus.lmmi_rdata_valid_i = NUM_CH'($urandom);
      bus.lmmi_rdata_i       = (NUM_CH*DATA_W)'($urandom);
      if (v.ch < NUM_CH) begin
        bus.lmmi_ready_i[v.ch] = (c - 1 == v.rdy_dly);
        if (v.wr == 0 && c - 1 >= v.rdy_dly)
          bus.lmmi_rdata_valid_i[v.ch] = (c - 1 == v.rdy_dly + v.vld_dly);
        if (c - 1 == v.rdy_dly + v.vld_dly)
          bus.lmmi_rdata_i[v.ch*DATA_W +: DATA_W] = DATA_W'(v.rdata);
      end
      @(negedge clk);
      if (bus.lmmi_request_o != '0) begin
        reqcnt++;
        if (reqcnt == 1) begin
          exp_v = 32'(1) << v.ch;
          chk({tag, " request"}, 32'(bus.lmmi_request_o), exp_v);
          exp_v = 32'(v.wr != 0) << v.ch;
          chk({tag, " wr_rdn"}, 32'(bus.lmmi_wr_rdn_o), exp_v);
          exp_v = 32'(v.off) << (v.ch * OFFSET_W);
          chk({tag, " offset"}, 32'(bus.lmmi_offset_o), exp_v);
          exp_v = 32'(v.wdata) << (v.ch * DATA_W);
          chk({tag, " wdata"}, 32'(bus.lmmi_wdata_o), exp_v);
        end
      end
      if (bus.rsp_valid_o) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " req cycles"}, 32'(reqcnt), 32'(v.exp_req));
    chk({tag, " err"}, 32'(bus.rsp_err_o), 32'(v.exp_err));
    chk({tag, " rdata"}, 32'(bus.rsp_rdata_o), 32'(v.exp_rdata));
    chk({tag, " cmd_ready in resp"}, 32'(bus.cmd_ready_o), 32'd0);
    hold_rd  = bus.rsp_rdata_o;
    hold_err = bus.rsp_err_o;
    for (int i = 0; i < v.bp; i++) begin
      @(negedge clk);
      chk({tag, " bp valid"}, 32'(bus.rsp_valid_o), 32'd1);
      chk({tag, " bp rdata"}, 32'(bus.rsp_rdata_o), 32'(hold_rd));
      chk({tag, " bp err"}, 32'(bus.rsp_err_o), 32'(hold_err));
      chk({tag, " bp cmd_ready"}, 32'(bus.cmd_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, " valid after hs"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, " cmd_ready after hs"}, 32'(bus.cmd_ready_o), 32'd1);
    @(posedge clk); #1;
  endtask

  vec_t tbl[10];
  vec_t rv;
  exp_t e;

  initial begin
    //        ch wr off    wd     rdy  vld  rdata bp  err rdata req  lat
    tbl[0] = '{2, 1, 'h05, 'hA3,  0,   0,   'h00, 0,  0, 'h00, 1,   2};
    tbl[1] = '{1, 0, 'h1F, 'h11,  3,   2,   'h5C, 0,  0, 'h5C, 4,   7};
    tbl[2] = '{7, 1, 'h02, 'h44,  0,   0,   'h00, 0,  2, 'h00, 0,   1};
    tbl[3] = '{0, 0, 'h0A, 'h00,  0,   0,   'h3C, 10, 0, 'h3C, 1,   2};
    tbl[4] = '{3, 1, 'h07, 'h99,  300, 0,   'h00, 0,  1, 'h00, 256, 257};
    tbl[5] = '{1, 1, 'h08, 'h5A,  255, 0,   'h00, 0,  0, 'h00, 256, 257};
    tbl[6] = '{2, 0, 'h13, 'h00,  1,   256, 'h77, 0,  0, 'h77, 2,   259};
    tbl[7] = '{2, 0, 'h14, 'h00,  0,   257, 'h88, 0,  1, 'h00, 1,   258};
    tbl[8] = '{15, 0, 'h01, 'h00, 0,   0,   'h00, 3,  2, 'h00, 0,   1};
    tbl[9] = '{3, 0, 'h1E, 'hFF,  2,   0,   'hE1, 0,  0, 'hE1, 3,   4};

    bus.cmd_valid_i = 0; bus.cmd_ch_i = '0; bus.cmd_wr_i = 0; bus.cmd_offset_i = '0;
    bus.cmd_wdata_i = '0; bus.rsp_ready_i = 0; bus.lmmi_ready_i = '0;
    bus.lmmi_rdata_i = '0; bus.lmmi_rdata_valid_i = '0;

    #12;
    chk("reset cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset request", 32'(bus.lmmi_request_o), 32'd0);
    chk("reset err/rdata", {22'd0, bus.rsp_err_o, bus.rsp_rdata_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("post-reset busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.ch      = $urandom_range(0, 5);
      rv.wr      = $urandom_range(0, 1);
      rv.off     = $urandom_range(0, 31);
      rv.wdata   = $urandom_range(0, 255);
      rv.rdy_dly = $urandom_range(0, 6);
      rv.vld_dly = $urandom_range(0, 4);
      rv.rdata   = $urandom_range(0, 255);
      rv.bp      = $urandom_range(0, 3);
      e = model(rv.ch, rv.wr, rv.rdy_dly, rv.vld_dly, rv.rdata);
      rv.exp_err = e.err; rv.exp_rdata = e.rdata; rv.exp_req = e.req; rv.exp_lat = e.lat;
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Abort a read while it waits for read data.
    bus.lmmi_ready_i = '0; bus.lmmi_rdata_valid_i = '0;
    bus.cmd_valid_i = 1'b1; bus.cmd_ch_i = 4'd1; bus.cmd_wr_i = 1'b0;
    bus.cmd_offset_i = 5'h0C; bus.cmd_wdata_i = 8'h00;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    bus.lmmi_ready_i = 4'b0010;
    @(posedge clk); #1;
    bus.lmmi_ready_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdwait busy", 32'(bus.busy_o), 32'd1);
    chk("rdwait request low", 32'(bus.lmmi_request_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy_o), 32'd0);
    chk("abort cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("abort rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("abort lmmi outs", {bus.lmmi_request_o, bus.lmmi_wr_rdn_o, bus.lmmi_offset_o[19:0]}, 32'd0);
    chk("abort wdata", 32'(bus.lmmi_wdata_o), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.lmmi_rdata_valid_i = 4'b0010;
    bus.lmmi_rdata_i = 32'h0000_AB00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no stale rsp", 32'(bus.rsp_valid_o), 32'd0);
      chk("idle cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    end
    bus.lmmi_rdata_valid_i = '0;
    @(posedge clk); #1;
    rv = '{0, 1, 'h03, 'h6D, 1, 0, 0, 0, 0, 0, 2, 3};
    run_txn(rv, "post-abort write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lmmi_cfg_bridge.md
Name: lmmi_cfg_bridge

Overview:
- Parametrised multi-channel LMMI configuration master.
- Takes single register-access commands from one host port (soft CPU or init sequencer) and routes each one to one of NUM_CH LMMI target ports: MIPI D-PHY RX/TX, I2C controllers, DDR PHY and similar.
- Handles the LMMI request/ready/rdata_valid handshake and per-access timeout, then returns one response per command.
- Replaces per-IP hand wiring of LMMI ports at the top level.

Parameters:
- NUM_CH, 4, number of LMMI target channels (1..16).
- DATA_W, 8, LMMI data width. Narrower targets (e.g. 4-bit D-PHY) use the low bits.
- OFFSET_W, 5, LMMI offset width. Narrower targets use the low bits.
- CH_W, 4, width of the channel index field.
- TIMEOUT, 255, cycles to wait for each handshake phase; 0 disables timeout.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous active-high reset.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o.
- cmd_ch_i  in  CH_W  target channel index.
- cmd_wr_i  in  1  1 = write, 0 = read.
- cmd_offset_i  in  OFFSET_W  register offset.
- cmd_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  host accepts response.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_err_o  out  2  response status: 0 ok, 1 timeout, 2 bad channel.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- lmmi_request_o  out  NUM_CH  per-channel request.
- lmmi_wr_rdn_o  out  NUM_CH  per-channel write/read select.
- lmmi_offset_o  out  NUM_CH*OFFSET_W  per-channel offset; channel k in slice k.
- lmmi_wdata_o  out  NUM_CH*DATA_W  per-channel write data.
- lmmi_ready_i  in  NUM_CH  per-channel ready.
- lmmi_rdata_i  in  NUM_CH*DATA_W  per-channel read data.
- lmmi_rdata_valid_i  in  NUM_CH  per-channel read data valid.

Behaviour:
- Reset, applied asynchronously:
  - FSM goes to IDLE; any in-flight command is discarded with no response.
  - All LMMI outputs are 0; rsp_valid_o, rsp_rdata_o, rsp_err_o and busy_o are 0.
  - cmd_ready_o is 1 once rst_i deasserts.
- FSM states are IDLE, REQ, RDWAIT and RESP. All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, latch ch, wr, offset and wdata.
  - If ch >= NUM_CH, go to RESP with err = 2 and rdata = 0; no LMMI activity.
  - Otherwise go to REQ and clear the timer.
- REQ:
  - lmmi_request_o[ch] = 1, and wr_rdn, offset and wdata are driven on slice ch only. All other slices, and all request bits, are 0.
  - Request stays high until lmmi_ready_i[ch] is sampled high.
  - On ready with a write, go to RESP with err = 0.
  - On ready with a read:
    - if lmmi_rdata_valid_i[ch] is high in the same cycle, capture rdata and go to RESP;
    - otherwise go to RDWAIT and clear the timer.
  - lmmi_rdata_valid_i seen before ready is ignored.
- RDWAIT:
  - Request is low.
  - On lmmi_rdata_valid_i[ch], capture lmmi_rdata_i slice ch and go to RESP with err = 0.
- Timeout:
  - In REQ and RDWAIT, when TIMEOUT != 0, the timer increments every cycle.
  - When the timer reaches TIMEOUT with no event, go to RESP with err = 1 and rdata = 0, and drop the request.
  - If the event and the timeout land in the same cycle, the event wins.
  - Timer width is clog2(TIMEOUT+1).
- RESP:
  - rsp_valid_o = 1, and rsp data and status are held stable until rsp_ready_i.
  - Then go to IDLE; cmd_ready_o rises the next cycle.
  - cmd_ready_o = 0 in every state except IDLE, so at most one command is outstanding.
- Ready and valid inputs on non-selected channels are ignored in all states.
- Latency for a write with zero-wait ready: command accepted in cycle 0, request high in cycle 1, rsp_valid_o high in cycle 2.
- Latency for a read with ready and rdata_valid both in cycle 1: rsp_valid_o high in cycle 2, with the data.

Test Plan:
- Write ch 2, offset 0x05, wdata 0xA3, with ready_i[2] high at the first request cycle:
  - request_o = 4'b0100 for exactly 1 cycle, offset slice 2 = 0x05, wdata slice 2 = 0xA3;
  - rsp_valid_o in cycle 2 with err = 0, rdata = 0.
- Read ch 1, offset 0x1F, ready after 3 cycles, rdata_valid 2 cycles later with data 0x5C:
  - request_o high for 4 cycles;
  - rsp_rdata_o = 0x5C, err = 0;
  - a rdata_valid pulse on ch 0 during the wait is ignored.
- Write ch 3 with ready_i never asserted, TIMEOUT = 255:
  - request drops after the timer reaches 255;
  - rsp_err_o = 1;
  - a new command is accepted after rsp_ready_i.
- Command with cmd_ch_i = 7 and NUM_CH = 4:
  - no request_o bit ever set;
  - rsp_valid_o 1 cycle after acceptance with err = 2.
- Backpressure: hold rsp_ready_i = 0 for 10 cycles:
  - rsp_valid_o and rdata remain stable;
  - cmd_ready_o stays 0;
  - cmd_ready_o = 1 the cycle after the response handshake.
- Assert rst_i while in RDWAIT:
  - all outputs go to 0 immediately;
  - no response for the aborted command;
  - after release, a write to ch 0 completes normally.
